// File: rtl/binary_to_bcd_ten_bit_pkg.sv
// Shared constants and the registered digit bundle
// for the 10-bit binary to BCD converter.
package binary_to_bcd_ten_bit_pkg;

  localparam int BIN_W       = 10;
  localparam int BCD_DIGIT_W = 4;
  localparam int MAX_IN      = 1023;
  localparam int BCD_W       = 3 * BCD_DIGIT_W + 1;

  typedef struct packed {
    logic                   thousands;
    logic [BCD_DIGIT_W-1:0] hundreds;
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] ones;
  } bcd_t;

endpackage

// File: rtl/binary_to_bcd_ten_bit_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a
// nibble of 5 or more so the next shift carries.
module bcd_add3
  import binary_to_bcd_ten_bit_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Inputs 10..15 never occur; they also get +3
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/binary_to_bcd_ten_bit.sv
// Combinational shift-and-add-3 network over the
// 10 input bits, followed by one registered bank.
module binary_to_bcd_ten_bit
  import binary_to_bcd_ten_bit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIN_W-1:0]       in,
  output logic [BCD_DIGIT_W-1:0] ones,
  output logic [BCD_DIGIT_W-1:0] tens,
  output logic [BCD_DIGIT_W-1:0] hundreds,
  output logic                   thousands
);

  logic [BCD_W-1:0] acc [0:BIN_W];
  logic [BCD_W-2:0] fix [0:BIN_W-1];
  logic [BIN_W-1:0] unused_msb;
  bcd_t             conv;
  bcd_t             digits;

  assign acc[0] = '0;

  genvar k;
  generate
    for (k = 0; k < BIN_W; k++) begin : g_step
      // Top bit only fills on the last shift
      assign unused_msb[k] = acc[k][BCD_W-1];

      if (k >= 3) begin : g_ones
        bcd_add3 u_ones (
          .din  (acc[k][3:0]),
          .dout (fix[k][3:0])
        );
      end else begin : g_ones_pass
        assign fix[k][3:0] = acc[k][3:0];
      end

      if (k >= 6) begin : g_tens
        bcd_add3 u_tens (
          .din  (acc[k][7:4]),
          .dout (fix[k][7:4])
        );
      end else begin : g_tens_pass
        assign fix[k][7:4] = acc[k][7:4];
      end

      if (k >= 9) begin : g_hund
        bcd_add3 u_hund (
          .din  (acc[k][11:8]),
          .dout (fix[k][11:8])
        );
      end else begin : g_hund_pass
        assign fix[k][11:8] = acc[k][11:8];
      end

      assign acc[k+1] = {fix[k], in[BIN_W-1-k]};
    end
  endgenerate

  assign conv = bcd_t'(acc[BIN_W]);

  // Digit register bank, cleared at once by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
    end else begin
      digits <= conv;
    end
  end

  assign ones      = digits.ones;
  assign tens      = digits.tens;
  assign hundreds  = digits.hundreds;
  assign thousands = digits.thousands;

endmodule

// File: tb/tb_binary_to_bcd_ten_bit.sv
// Scoreboard bench for binary_to_bcd_ten_bit:
// stimulus queues expectations, monitor checks.
`timescale 1ns/1ps
module tb_binary_to_bcd_ten_bit;
  import binary_to_bcd_ten_bit_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [BIN_W-1:0]       in;
  logic [BCD_DIGIT_W-1:0] ones;
  logic [BCD_DIGIT_W-1:0] tens;
  logic [BCD_DIGIT_W-1:0] hundreds;
  logic                   thousands;

  int compared;
  int mismatched;
  bit done;

  logic [12:0] expq [$];

  binary_to_bcd_ten_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pk(
    input int th, input int h,
    input int t, input int o);
    logic [12:0] r;
    r = {th[0], h[3:0], t[3:0], o[3:0]};
    return r;
  endfunction

  function automatic logic [12:0] model(input int v);
    return pk(v / 1000, (v / 100) % 10,
              (v / 10) % 10, v % 10);
  endfunction

  function automatic logic [12:0] dut_out();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic check(input string name,
                       input logic [12:0] act,
                       input logic [12:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h/%h/%h/%h want %h/%h/%h/%h",
               name, act[12], act[11:8], act[7:4], act[3:0],
               exp[12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic apply(input int v, input logic [12:0] exp);
    @(negedge clk);
    in = v[BIN_W-1:0];
    expq.push_back(exp);
  endtask

  // Monitor: one registered result per edge
  initial begin
    logic [12:0] e;
    logic [12:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = dut_out();
        check("result", a, e);
        compared++;
        if (a[11:8] > 4'd9 || a[7:4] > 4'd9 ||
            a[3:0] > 4'd9) begin
          mismatched++;
          $display("FAIL bcd_range: got %h/%h/%h/%h want digits<=9",
                   a[12], a[11:8], a[7:4], a[3:0]);
        end
      end
    end
  end

  initial begin
    int budget;
    done = 1'b0;
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    in = 10'd1023;

    #1 rst = 1'b1;
    #2 check("reset_async", dut_out(), pk(0, 0, 0, 0));
    @(posedge clk);
    #1 check("reset_hold", dut_out(), pk(0, 0, 0, 0));

    @(negedge clk);
    rst = 1'b0;
    expq.push_back(pk(1, 0, 2, 3));

    apply(9,    pk(0, 0, 0, 9));
    apply(10,   pk(0, 0, 1, 0));
    apply(99,   pk(0, 0, 9, 9));
    apply(100,  pk(0, 1, 0, 0));
    apply(999,  pk(0, 9, 9, 9));
    apply(1000, pk(1, 0, 0, 0));
    apply(0,    pk(0, 0, 0, 0));
    apply(1023, pk(1, 0, 2, 3));
    apply(512,  pk(0, 5, 1, 2));
    apply(255,  pk(0, 2, 5, 5));

    for (int v = 0; v <= MAX_IN; v++) begin
      apply(v, model(v));
    end

    apply(512, pk(0, 5, 1, 2));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("mid_reset", dut_out(), pk(0, 0, 0, 0));
    @(negedge clk);
    in = 10'd777;
    @(posedge clk);
    #1 check("mid_reset_hold", dut_out(), pk(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    expq.push_back(pk(0, 7, 7, 7));

    @(negedge clk);
    in = 10'd5;
    expq.push_back(pk(0, 5, 0, 0));
    #1 in = 10'd500;
    #1 in = 10'd5;
    #1 in = 10'd500;
    #1 check("glitch_hold", dut_out(), pk(0, 7, 7, 7));

    @(negedge clk);
    in = 10'd500;
    expq.push_back(pk(0, 0, 0, 5));
    #1 in = 10'd5;
    #1 in = 10'd500;
    #1 in = 10'd5;
    #1 check("glitch_hold2", dut_out(), pk(0, 5, 0, 0));

    budget = 20;
    while (expq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expq.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending want 0",
               expq.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
    end
  end

endmodule
